// File: rtl/pcs_tx_ordered_set_if.sv
// GMII-side transmit bundle and code-group output of the PCS ordered-set generator.
// The master drives TX_EN/TXD and observes the code-group stream; the slave is the generator.
interface pcs_tx_ordered_set_if #(
  parameter int FRAME_CNT_W = 16
);
  logic                   tx_en;
  logic [7:0]             txd;
  logic [7:0]             tx_code;
  logic                   tx_k;
  logic                   tx_even;
  logic [FRAME_CNT_W-1:0] tx_frames;

  modport master (
    output tx_en, txd,
    input  tx_code, tx_k, tx_even, tx_frames
  );

  modport slave (
    input  tx_en, txd,
    output tx_code, tx_k, tx_even, tx_frames
  );
endinterface

// File: rtl/pcs_tx_ordered_set.sv
// 1000BASE-X PCS transmit ordered-set generator: turns GMII frames into /I2/, /S/, data,
// /T/R/ or /T/R/R/ code-groups with a K flag, keeping /S/ and idles on even positions.
module pcs_tx_ordered_set #(
  parameter int FRAME_CNT_W = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  pcs_tx_ordered_set_if.slave  bus
);

  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] D16_2 = 8'h50;
  localparam logic [7:0] K27_7 = 8'hFB;
  localparam logic [7:0] K29_7 = 8'hFD;
  localparam logic [7:0] K23_7 = 8'hF7;

  typedef enum logic [2:0] {
    IDLE_K,
    IDLE_D,
    SOP,
    DATA,
    EOP_T,
    EOP_R,
    EOP_R2
  } state_e;

  state_e                 state_q, state_d;
  logic                   tx_en_q;
  logic [7:0]             txd_q;
  logic [7:0]             code_q, code_d;
  logic                   k_q, k_d;
  logic                   even_q;
  logic [FRAME_CNT_W-1:0] frames_q, frames_d;

  // state_q is the code-group currently on the output; its successor is registered with its output
  always_comb begin
    state_d  = state_q;
    code_d   = K28_5;
    k_d      = 1'b1;
    frames_d = frames_q;

    case (state_q)
      IDLE_K:  state_d = IDLE_D;
      IDLE_D:  state_d = tx_en_q ? SOP : IDLE_K;
      SOP:     state_d = tx_en_q ? DATA : EOP_T;
      DATA:    state_d = tx_en_q ? DATA : EOP_T;
      EOP_T:   state_d = EOP_R;
      EOP_R:   state_d = even_q ? EOP_R2 : IDLE_K;
      EOP_R2:  state_d = IDLE_K;
      default: state_d = IDLE_K;
    endcase

    case (state_d)
      IDLE_K:  begin code_d = K28_5; k_d = 1'b1; end
      IDLE_D:  begin code_d = D16_2; k_d = 1'b0; end
      SOP:     begin code_d = K27_7; k_d = 1'b1; end
      DATA:    begin code_d = txd_q; k_d = 1'b0; end
      EOP_T:   begin code_d = K29_7; k_d = 1'b1; end
      EOP_R:   begin code_d = K23_7; k_d = 1'b1; end
      EOP_R2:  begin code_d = K23_7; k_d = 1'b1; end
      default: begin code_d = K28_5; k_d = 1'b1; end
    endcase

    if (state_d == SOP && frames_q != '1) begin
      frames_d = frames_q + FRAME_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE_K;
      code_q   <= K28_5;
      k_q      <= 1'b1;
      even_q   <= 1'b1;
      frames_q <= '0;
      tx_en_q  <= 1'b0;
      txd_q    <= 8'h00;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      k_q      <= k_d;
      even_q   <= ~even_q;
      frames_q <= frames_d;
      tx_en_q  <= bus.tx_en;
      txd_q    <= bus.txd;
    end
  end

  assign bus.tx_code   = code_q;
  assign bus.tx_k      = k_q;
  assign bus.tx_even   = even_q;
  assign bus.tx_frames = frames_q;

endmodule

// File: tb/tb_pcs_tx_ordered_set.sv
// Self-checking bench for pcs_tx_ordered_set: directed and random GMII streams are compared
// against a frame-level model of the code-group stream; a 2-bit counter copy checks saturation.
module tb_pcs_tx_ordered_set;

  localparam int MAXL = 520;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pcs_tx_ordered_set_if #(.FRAME_CNT_W(16)) bus ();
  pcs_tx_ordered_set_if #(.FRAME_CNT_W(2))  busSat ();

  pcs_tx_ordered_set #(.FRAME_CNT_W(16)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.slave)
  );

  pcs_tx_ordered_set #(.FRAME_CNT_W(2)) dutSat (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (busSat.slave)
  );

  int checks;
  int failures;

  logic       stimEn    [MAXL+8];
  logic [7:0] stimD     [MAXL+8];
  logic [7:0] obsCode   [MAXL+8];
  logic       obsK      [MAXL+8];
  logic       obsEven   [MAXL+8];
  logic [15:0] obsFrames[MAXL+8];
  logic [1:0] obsSat    [MAXL+8];
  logic [7:0] expCode   [MAXL+8];
  logic       expK      [MAXL+8];
  int         expFrames [MAXL+8];

  task automatic clearStim();
    for (int i = 0; i < MAXL + 8; i++) begin
      stimEn[i] = 1'b0;
      stimD[i]  = 8'h00;
    end
  endtask

  task automatic capture(input int t);
    obsCode[t]   = bus.tx_code;
    obsK[t]      = bus.tx_k;
    obsEven[t]   = bus.tx_even;
    obsFrames[t] = bus.tx_frames;
    obsSat[t]    = busSat.tx_frames;
  endtask

  task automatic driveInputs(input logic en, input logic [7:0] d);
    bus.tx_en    = en;
    bus.txd      = d;
    busSat.tx_en = en;
    busSat.txd   = d;
  endtask

  // Index t is the code-group presented after the t-th rising edge following reset release
  task automatic doReset();
    rst_n = 1'b0;
    driveInputs(1'b0, 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    capture(0);
  endtask

  task automatic applyStimulus(input int len);
    for (int t = 1; t <= len; t++) begin
      driveInputs(stimEn[t], stimD[t]);
      @(posedge clk);
      #1;
      capture(t);
    end
    driveInputs(1'b0, 8'h00);
  endtask

  task automatic setExp(input int p, input logic [7:0] c, input logic k, input int n);
    expCode[p]   = c;
    expK[p]      = k;
    expFrames[p] = n;
  endtask

  // Walks the output timeline frame by frame: idle pairs, a start decision on each odd slot,
  // then /S/, the data run, /T/, and one or two /R/ so that the next idle lands even.
  task automatic buildExpected(input int len);
    int p;
    int n;
    p = 0;
    n = 0;
    setExp(0, 8'hBC, 1'b1, 0);
    while (p < len) begin
      p++;
      setExp(p, 8'h50, 1'b0, n);
      if (p < len && stimEn[p]) begin
        p++;
        n++;
        setExp(p, 8'hFB, 1'b1, n);
        while (p < len && stimEn[p]) begin
          p++;
          setExp(p, stimD[p-1], 1'b0, n);
        end
        p++;
        setExp(p, 8'hFD, 1'b1, n);
        p++;
        setExp(p, 8'hF7, 1'b1, n);
        if ((p % 2) == 0) begin
          p++;
          setExp(p, 8'hF7, 1'b1, n);
        end
      end
      p++;
      setExp(p, 8'hBC, 1'b1, n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    driveInputs(1'b0, 8'h00);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (bus.tx_code !== 8'hBC || bus.tx_k !== 1'b1 || bus.tx_even !== 1'b1 ||
          bus.tx_frames !== 16'd0 || busSat.tx_frames !== 2'd0) begin
        failures++;
        $display("[TB] FAIL reset_hold code=%h k=%b even=%b frames=%0d got, expected bc 1 1 0",
                 bus.tx_code, bus.tx_k, bus.tx_even, bus.tx_frames);
      end
    end
    rst_n = 1'b1;
    capture(0);
    clearStim();
    applyStimulus(10);
    buildExpected(10);
    for (int t = 0; t <= 10; t++) begin
      checks++;
      if (obsCode[t] !== expCode[t] || obsK[t] !== expK[t] || obsEven[t] !== ((t % 2) == 0)) begin
        failures++;
        $display("[TB] FAIL reset_idle t=%0d got %h/%b even=%b, expected %h/%b even=%b",
                 t, obsCode[t], obsK[t], obsEven[t], expCode[t], expK[t], (t % 2) == 0);
      end
    end
  endtask

  task automatic test_aligned_frames();
    logic [7:0] bytes [10];
    bytes = '{8'hFB, 8'h1C, 8'h1D, 8'h1E, 8'h1F, 8'h20, 8'h21, 8'h22, 8'h23, 8'h24};
    doReset();
    clearStim();
    for (int i = 0; i < 10; i++) begin
      stimEn[5 + i]  = 1'b1;
      stimD[5 + i]   = bytes[i];
      stimEn[20 + i] = 1'b1;
      stimD[20 + i]  = bytes[i];
    end
    stimEn[35] = 1'b1;
    stimD[35]  = 8'hAA;
    applyStimulus(44);
    buildExpected(44);
    for (int t = 0; t <= 44; t++) begin
      checks++;
      if (obsCode[t] !== expCode[t] || obsK[t] !== expK[t] || obsEven[t] !== ((t % 2) == 0) ||
          obsFrames[t] !== 16'(expFrames[t])) begin
        failures++;
        $display("[TB] FAIL aligned_frames t=%0d got %h/%b even=%b n=%0d, expected %h/%b even=%b n=%0d",
                 t, obsCode[t], obsK[t], obsEven[t], obsFrames[t], expCode[t], expK[t],
                 (t % 2) == 0, expFrames[t]);
      end
    end
    checks++;
    if (obsCode[6] !== 8'hFB || obsCode[15] !== 8'h24 || obsCode[17] !== 8'hF7 ||
        obsCode[18] !== 8'hBC || obsCode[22] !== 8'hFB || obsCode[23] !== 8'h1D ||
        obsCode[33] !== 8'hF7 || obsFrames[44] !== 16'd3) begin
      failures++;
      $display("[TB] FAIL aligned_landmarks got %h %h %h %h %h %h %h n=%0d, expected fb 24 f7 bc fb 1d f7 n=3",
               obsCode[6], obsCode[15], obsCode[17], obsCode[18], obsCode[22], obsCode[23],
               obsCode[33], obsFrames[44]);
    end
  endtask

  task automatic test_back_to_back();
    doReset();
    clearStim();
    for (int t = 5; t <= 10; t++) begin
      stimEn[t] = 1'b1;
      stimD[t]  = 8'($urandom);
    end
    for (int t = 12; t <= 30; t++) begin
      stimEn[t] = 1'b1;
      stimD[t]  = 8'($urandom);
    end
    applyStimulus(50);
    buildExpected(50);
    for (int t = 0; t <= 50; t++) begin
      checks++;
      if (obsCode[t] !== expCode[t] || obsK[t] !== expK[t] || obsEven[t] !== ((t % 2) == 0) ||
          obsFrames[t] !== 16'(expFrames[t])) begin
        failures++;
        $display("[TB] FAIL back_to_back t=%0d got %h/%b even=%b n=%0d, expected %h/%b even=%b n=%0d",
                 t, obsCode[t], obsK[t], obsEven[t], obsFrames[t], expCode[t], expK[t],
                 (t % 2) == 0, expFrames[t]);
      end
    end
  endtask

  task automatic test_random();
    logic en;
    en = 1'b0;
    doReset();
    clearStim();
    for (int t = 1; t <= 500; t++) begin
      if ($urandom_range(0, 5) == 0) en = ~en;
      stimEn[t] = en;
      stimD[t]  = 8'($urandom);
    end
    applyStimulus(500);
    buildExpected(500);
    for (int t = 0; t <= 500; t++) begin
      checks++;
      if (obsCode[t] !== expCode[t] || obsK[t] !== expK[t] || obsEven[t] !== ((t % 2) == 0) ||
          obsFrames[t] !== 16'(expFrames[t])) begin
        failures++;
        $display("[TB] FAIL random t=%0d got %h/%b even=%b n=%0d, expected %h/%b even=%b n=%0d",
                 t, obsCode[t], obsK[t], obsEven[t], obsFrames[t], expCode[t], expK[t],
                 (t % 2) == 0, expFrames[t]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    doReset();
    clearStim();
    for (int t = 5; t <= 20; t++) begin
      stimEn[t] = 1'b1;
      stimD[t]  = 8'(t);
    end
    applyStimulus(11);
    driveInputs(1'b1, 8'h5A);
    buildExpected(11);
    checks++;
    if (obsCode[11] !== expCode[11] || obsK[11] !== 1'b0 || obsFrames[11] !== 16'd1) begin
      failures++;
      $display("[TB] FAIL pre_reset_data got %h/%b n=%0d, expected %h/0 n=1",
               obsCode[11], obsK[11], obsFrames[11], expCode[11]);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.tx_code !== 8'hBC || bus.tx_k !== 1'b1 || bus.tx_even !== 1'b1 ||
        bus.tx_frames !== 16'd0) begin
      failures++;
      $display("[TB] FAIL async_reset got %h/%b even=%b n=%0d, expected bc/1 even=1 n=0",
               bus.tx_code, bus.tx_k, bus.tx_even, bus.tx_frames);
    end
    doReset();
    clearStim();
    applyStimulus(8);
    buildExpected(8);
    for (int t = 0; t <= 8; t++) begin
      checks++;
      if (obsCode[t] !== expCode[t] || obsK[t] !== expK[t] || obsEven[t] !== ((t % 2) == 0) ||
          obsFrames[t] !== 16'd0) begin
        failures++;
        $display("[TB] FAIL post_reset_idle t=%0d got %h/%b even=%b n=%0d, expected %h/%b even=%b n=0",
                 t, obsCode[t], obsK[t], obsEven[t], obsFrames[t], expCode[t], expK[t],
                 (t % 2) == 0);
      end
    end
  endtask

  task automatic test_saturation();
    int satExp;
    doReset();
    clearStim();
    for (int f = 0; f < 5; f++) begin
      stimEn[5 + 6 * f] = 1'b1;
    end
    applyStimulus(36);
    buildExpected(36);
    for (int t = 0; t <= 36; t++) begin
      satExp = (expFrames[t] > 3) ? 3 : expFrames[t];
      checks++;
      if (obsCode[t] !== expCode[t] || obsK[t] !== expK[t] ||
          obsFrames[t] !== 16'(expFrames[t]) || obsSat[t] !== 2'(satExp)) begin
        failures++;
        $display("[TB] FAIL saturation t=%0d got %h/%b n=%0d sat=%0d, expected %h/%b n=%0d sat=%0d",
                 t, obsCode[t], obsK[t], obsFrames[t], obsSat[t], expCode[t], expK[t],
                 expFrames[t], satExp);
      end
    end
    checks++;
    if (obsFrames[36] !== 16'd5 || obsSat[36] !== 2'd3) begin
      failures++;
      $display("[TB] FAIL saturation_final got n=%0d sat=%0d, expected n=5 sat=3",
               obsFrames[36], obsSat[36]);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    driveInputs(1'b0, 8'h00);
    #3;
    test_reset();
    test_aligned_frames();
    test_back_to_back();
    test_random();
    test_reset_mid_frame();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pcs_tx_ordered_set.md
# pcs_tx_ordered_set

PCS transmit ordered-set generator for the 1000BASE-X PCS. It sits directly downstream of the GMII transmit interface (TX_EN/TXD) and upstream of the 8B/10B encoder. It converts GMII frames into a code-group stream with a K-flag: /I2/ idles, /S/ start, data pass-through, and /T/R/ or /T/R/R/ end-of-packet with even alignment. Running disparity and the 10-bit mapping belong to the encoder, not this block.

## Interface
- FRAME_CNT_W, 16, width of the transmitted-frame counter.

- CLK  in  1  single clock; all state updates on its rising edge.
- RESET  in  1  asynchronous, active-low reset.
- TX_EN  in  1  GMII transmit enable.
- TXD  in  8  GMII transmit data.
- TX_CODE  out  8  code-group octet to the encoder (HGFEDCBA).
- TX_K  out  1  1 = TX_CODE is a K code-group.
- TX_EVEN  out  1  1 = current code-group occupies an even position.
- TX_FRAMES  out  FRAME_CNT_W  number of /S/ emitted, saturating.

## Operation
- Input stage: TX_EN and TXD are registered every edge into tx_en_r/txd_r. All FSM decisions use tx_en_r.
- Code values:
  - K28.5 = 0xBC (K)
  - D16.2 = 0x50 (D)
  - /S/ K27.7 = 0xFB (K)
  - /T/ K29.7 = 0xFD (K)
  - /R/ K23.7 = 0xF7 (K)
- TX_EVEN toggles on every edge with no exception; it is 1 during reset.
- FSM states and the output each state drives:
  - IDLE_K: drives 0xBC/K. Always goes to IDLE_D.
  - IDLE_D: drives 0x50/D. Goes to SOP if tx_en_r=1, else IDLE_K.
  - SOP: drives 0xFB/K. The byte in txd_r is discarded. Increments TX_FRAMES unless it is all-ones. Goes to DATA if tx_en_r=1, else EOP_T.
  - DATA: drives txd_r with K=0. Stays in DATA while tx_en_r=1, else goes to EOP_T.
  - EOP_T: drives 0xFD/K. Always goes to EOP_R.
  - EOP_R: drives 0xF7/K. Goes to IDLE_K if this /R/ is odd; goes to EOP_R2 if it is even.
  - EOP_R2: drives 0xF7/K (always odd). Goes to IDLE_K.
- /S/ always lands on an even position, because IDLE_D is always odd. IDLE_K is always even after EOP.
- tx_en_r is ignored in IDLE_K, EOP_T, EOP_R and EOP_R2. Bytes presented then are dropped. A frame starts only at the IDLE_D decision.
- If tx_en_r first rises while IDLE_K is driven, that byte is lost in the D16.2 slot and the next byte is replaced by /S/. If it first rises while IDLE_D is driven, that byte itself is replaced by /S/.
- No TX_ER, carrier extension or configuration ordered sets; this block handles data mode only.

## Timing
- Reset (async assert, RESET=0) forces:
  - TX_CODE=0xBC, TX_K=1, TX_EVEN=1
  - state register = IDLE_K output already presented, so the first edge after release drives IDLE_D
  - TX_FRAMES=0, tx_en_r=0, txd_r=0
- Reset mid-frame truncates the frame with no /T/. Outputs take reset values immediately, without waiting for a clock.
- Latency: a byte sampled on TXD at edge n appears on TX_CODE from edge n+1, and every output is registered.
- End of frame: tx_en_r=0 seen in DATA at edge m gives /T/ from m, /R/ from m+1, and either IDLE_K from m+2 or /R/ from m+2 then IDLE_K from m+3.
- Frame length: with N data bytes after /S/, N odd gives a single /R/ and N even (including 0) gives /R/R/.
- TX_FRAMES updates on the edge that drives /S/ and saturates at 2^FRAME_CNT_W−1.

## Test plan
- Reset with TX_EN=0 → during reset TX_CODE=0xBC, K=1, EVEN=1. After release the stream is 0x50, 0xBC, 0x50, … and TX_EVEN alternates every cycle.
- TX_EN rises, aligned to IDLE_D, with bytes FB,1C,1D,1E,1F,20,21,22,23,24, then drops → FB/K, then 1C..24 with K=0 (N=9), then FD/K, F7/K (odd), then 0xBC even. TX_FRAMES=1.
- Same frame but TX_EN rises aligned to IDLE_K → FB is lost in the 0x50 slot and 1C is replaced by /S/. The data run is 1D..24 (N=8), ending FD, F7, F7, then 0xBC even.
- One-cycle TX_EN pulse at the IDLE_D decision → FB/K, FD/K, F7/K (even), F7/K (odd), 0xBC. TX_FRAMES increments.
- Drop TX_EN then reassert it one cycle later → the reassertion is ignored during EOP. The next frame starts at the next IDLE_D decision and /S/ lands even.
- Assert RESET low mid-DATA → outputs jump to 0xBC/K/EVEN=1 asynchronously and TX_FRAMES=0. After release, idle resumes with no /T/. Separately, with FRAME_CNT_W=2, send 5 frames → TX_FRAMES holds at 3.
